// File: rtl/rs232_rx_fifo.sv
// RS232 receiver with majority-voted sampling feeding a first-word-fall-through receive FIFO.
// Latency: a character enters the FIFO in the middle of its stop bit; rdy rises the cycle after that.
// Backpressure: none on the line side; a character that arrives while the FIFO is full is dropped and sets sticky ovr.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rxd                 asynchronous serial input, idle high
//   div                 bit period in clk cycles (>= 16), sampled live
//   par_mode            00 none, 01 odd, 10 even, 11 none
//   done                pop the head entry (ignored when empty)
//   clr_ovr             clear the sticky overrun flag
//   rdy                 FIFO holds at least one entry
//   data_out, fe, pe    head character and its framing/parity error flags (0 when empty)
//   ovr                 sticky: a complete character was dropped on a full FIFO
//   count               FIFO occupancy

module rs232_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic [15:0]                   div,
  input  logic [1:0]                    par_mode,
  input  logic                          done,
  input  logic                          clr_ovr,
  output logic                          rdy,
  output logic [7:0]                    data_out,
  output logic                          fe,
  output logic                          pe,
  output logic                          ovr,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;  // {pe, fe, data}

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // ------------------------------------------------------------------
  // Line synchroniser and edge detect
  // ------------------------------------------------------------------
  logic rx_s0;
  logic rx_s1;
  logic rx_s1_d;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s0   <= 1'b1;
      rx_s1   <= 1'b1;
      rx_s1_d <= 1'b1;
    end else begin
      rx_s0   <= rxd;
      rx_s1   <= rx_s0;
      rx_s1_d <= rx_s1;
    end
  end

  // Only a high-to-low transition starts a frame, so after a break the
  // receiver stays idle until the line has gone high again.
  assign fall = rx_s1_d & ~rx_s1;

  // ------------------------------------------------------------------
  // Bit timing and majority sampling
  // ------------------------------------------------------------------
  logic [2:0]           state;
  logic [15:0]          tick;
  logic [15:0]          tick_nxt;
  logic [2:0]           bitcnt;
  logic                 smp_a;
  logic                 smp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_r;

  logic [15:0] half;
  logic [15:0] half_m1;
  logic [15:0] half_p1;
  logic [15:0] div_m1;
  logic        bit_end;
  logic        at_a;
  logic        at_b;
  logic        at_smp;
  logic        smp_val;
  logic        par_en;

  always_comb begin
    half     = div >> 1;
    half_m1  = half - 16'd1;
    half_p1  = half + 16'd1;
    div_m1   = div - 16'd1;
    bit_end  = (tick == div_m1);
    at_a     = (tick == half_m1);
    at_b     = (tick == half);
    at_smp   = (tick == half_p1);
    tick_nxt = bit_end ? 16'd0 : tick + 16'd1;
    // Two earlier samples are held in smp_a/smp_b; the third is the live s1.
    smp_val  = (smp_a & smp_b) | (smp_a & rx_s1) | (smp_b & rx_s1);
    par_en   = (par_mode == 2'b01) || (par_mode == 2'b10);
  end

  // ------------------------------------------------------------------
  // Receive FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      tick   <= 16'd0;
      bitcnt <= 3'd0;
      smp_a  <= 1'b1;
      smp_b  <= 1'b1;
      shreg  <= '0;
      pe_r   <= 1'b0;
    end else begin
      if (at_a) smp_a <= rx_s1;
      if (at_b) smp_b <= rx_s1;

      case (state)
        ST_IDLE: begin
          tick   <= 16'd0;
          bitcnt <= 3'd0;
          if (fall) begin
            state <= ST_START;
            pe_r  <= 1'b0;
          end
        end

        ST_START: begin
          tick <= tick_nxt;
          if (at_smp && smp_val) begin
            // Line was back high by mid-bit: treat as a glitch.
            state <= ST_IDLE;
            tick  <= 16'd0;
          end else if (bit_end) begin
            state  <= ST_DATA;
            bitcnt <= 3'd0;
          end
        end

        ST_DATA: begin
          tick <= tick_nxt;
          // LSB arrives first, so shift in from the top; after DATA_BITS
          // samples the first bit sits at shreg[0].
          if (at_smp) shreg <= {smp_val, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bitcnt == LAST_BIT) begin
              state <= par_en ? ST_PARITY : ST_STOP;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end

        ST_PARITY: begin
          tick <= tick_nxt;
          // Total ones (data + parity bit) must be odd for odd mode, even for even mode.
          if (at_smp) pe_r <= ((^shreg) ^ smp_val) != (par_mode == 2'b01);
          if (bit_end) state <= ST_STOP;
        end

        ST_STOP: begin
          tick <= tick_nxt;
          // Leave at the stop-bit sample point so the next start edge,
          // which may follow the stop bit directly, is not missed.
          if (at_smp) begin
            state <= ST_IDLE;
            tick  <= 16'd0;
          end
        end

        default: begin
          state <= ST_IDLE;
          tick  <= 16'd0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // ------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_req;
  logic [EW-1:0] push_dat;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [EW-1:0] head;

  always_comb begin
    push_req = (state == ST_STOP) && at_smp;
    push_dat = {pe_r, ~smp_val, shreg};
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    pop      = done && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en    = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;

      if (wr_en && !pop)      count <= count + CNT_ONE;
      else if (!wr_en && pop) count <= count - CNT_ONE;

      // A drop wins over a simultaneous clear so the loss is never hidden.
      if (drop)         ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

  // Head is shown straight from storage; outputs read 0 while empty so the
  // reset state is clean without clearing the array.
  always_comb begin
    head     = mem[rd_ptr];
    rdy      = !empty;
    data_out = 8'd0;
    fe       = 1'b0;
    pe       = 1'b0;
    if (!empty) begin
      data_out[DATA_BITS-1:0] = head[DATA_BITS-1:0];
      fe                      = head[DATA_BITS];
      pe                      = head[DATA_BITS+1];
    end
  end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
module tb_rs232_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance with a 4-deep FIFO
  logic        rxd8 = 1'b1, done8 = 1'b0, clr8 = 1'b0;
  logic [15:0] div8 = 16'd16;
  logic [1:0]  pm8 = 2'b00;
  logic        rdy8, fe8, pe8, ovr8;
  logic [7:0]  dout8;
  logic [2:0]  cnt8;

  // 7-bit instance with a 16-deep FIFO
  logic        rxd7 = 1'b1, done7 = 1'b0, clr7 = 1'b0;
  logic [15:0] div7 = 16'd434;
  logic [1:0]  pm7 = 2'b00;
  logic        rdy7, fe7, pe7, ovr7;
  logic [7:0]  dout7;
  logic [4:0]  cnt7;

  rs232_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd8), .div(div8), .par_mode(pm8),
    .done(done8), .clr_ovr(clr8), .rdy(rdy8), .data_out(dout8),
    .fe(fe8), .pe(pe8), .ovr(ovr8), .count(cnt8)
  );

  rs232_rx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(16)) u7 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd7), .div(div7), .par_mode(pm7),
    .done(done7), .clr_ovr(clr7), .rdy(rdy7), .data_out(dout7),
    .fe(fe7), .pe(pe7), .ovr(ovr7), .count(cnt7)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  q8[$];     // reference FIFO contents {pe, fe, data}
  logic        ovr_m;
  logic        mid_rdy;   // rdy captured early in the stop bit
  logic [16:0] snap;      // u7 outputs captured just after reset assertion

  // Reference: what a character should look like once received.
  function automatic logic [9:0] exp_entry(input logic [7:0] d, input int nb,
                                           input logic [1:0] pm, input logic pbit,
                                           input logic sbit);
    logic [7:0] dm;
    int         ones;
    logic       pe_e;
    dm = 8'd0;
    for (int k = 0; k < nb; k++) dm[k] = d[k];
    ones = $countones(dm) + int'(pbit);
    if (pm == 2'b01)      pe_e = (ones % 2) != 1;
    else if (pm == 2'b10) pe_e = (ones % 2) != 0;
    else                  pe_e = 1'b0;
    return {pe_e, ~sbit, dm};
  endfunction

  function automatic bit par_on(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pop(input bit sel7);
    if (sel7) done7 = 1'b1; else done8 = 1'b1;
    wait_cyc(1);
    done7 = 1'b0;
    done8 = 1'b0;
  endtask

  // Drives one frame, one cycle per iteration. Optional single-cycle spike,
  // a one-cycle done pulse at cycle done_at, and a one-cycle reset at rst_at.
  task automatic send_frame(input bit sel7, input logic [7:0] d, input int nb,
                            input bit pen, input logic pbit, input logic sbit,
                            input int dv, input int spike_bit, input int spike_off,
                            input int done_at, input int rst_at);
    logic bits [12];
    int   total;
    int   b;
    logic v;
    bits[0] = 1'b0;
    for (int k = 0; k < nb; k++) bits[k+1] = d[k];
    if (pen) bits[nb+1] = pbit;
    total = nb + 2 + (pen ? 1 : 0);
    bits[total-1] = sbit;
    for (int i = 0; i < total * dv; i++) begin
      b = i / dv;
      v = bits[b];
      if (b == spike_bit && (i % dv) == spike_off) v = ~v;
      if (sel7) rxd7 = v; else rxd8 = v;
      if (!sel7) done8 = (i == done_at);
      if (i == (total - 1) * dv + dv / 4) mid_rdy = sel7 ? rdy7 : rdy8;
      if (i == rst_at + 1) rst_n = 1'b1;
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        snap = {rdy7, dout7, fe7, pe7, ovr7, cnt7};
      end
      wait_cyc(1);
    end
    rxd7 = 1'b1;
    rxd8 = 1'b1;
    done8 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_cyc(3);
    n_tests++;
    if ({rdy8, dout8, fe8, pe8, ovr8, cnt8} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_u8_in: got rdy=%b d=%h fe=%b pe=%b ovr=%b cnt=%0d, want all 0",
               rdy8, dout8, fe8, pe8, ovr8, cnt8);
    end
    rst_n = 1'b1;
    wait_cyc(3);
    n_tests++;
    if ({rdy8, dout8, fe8, pe8, ovr8, cnt8} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_u8_out: got rdy=%b d=%h fe=%b pe=%b ovr=%b cnt=%0d, want all 0",
               rdy8, dout8, fe8, pe8, ovr8, cnt8);
    end
    n_tests++;
    if ({rdy7, dout7, fe7, pe7, ovr7, cnt7} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_u7: got rdy=%b d=%h cnt=%0d, want 0 0 0", rdy7, dout7, cnt7);
    end
  endtask

  task automatic test_basic;
    div8 = 16'd16;
    pm8  = 2'b00;
    send_frame(1'b0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 16, -1, 0, -1, -1);
    n_tests++;
    if (mid_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: rdy=%b before stop sample, want 0", mid_rdy);
    end
    n_tests++;
    if ({rdy8, dout8, fe8, pe8, cnt8} !== {1'b1, 8'h55, 1'b0, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL basic_rx: got rdy=%b d=%h fe=%b pe=%b cnt=%0d, want 1 55 0 0 1",
               rdy8, dout8, fe8, pe8, cnt8);
    end
    do_pop(1'b0);
    n_tests++;
    if ({rdy8, cnt8} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL basic_pop: got rdy=%b cnt=%0d, want 0 0", rdy8, cnt8);
    end
  endtask

  task automatic test_parity;
    logic [1:0] pms [3];
    logic       pbs [3];
    pms = '{2'b10, 2'b10, 2'b01};
    pbs = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      pm8 = pms[k];
      send_frame(1'b0, 8'hA3, 8, 1'b1, pbs[k], 1'b1, 16, -1, 0, -1, -1);
      q8.push_back(exp_entry(8'hA3, 8, pms[k], pbs[k], 1'b1));
    end
    n_tests++;
    if (cnt8 !== 3'd3) begin
      n_fail++;
      $display("FAIL parity_cnt: got %0d want 3", cnt8);
    end
    while (q8.size() > 0) begin
      n_tests++;
      if ({rdy8, pe8, fe8, dout8} !== {1'b1, q8[0]}) begin
        n_fail++;
        $display("FAIL parity_entry: got rdy=%b pe=%b fe=%b d=%h want pe=%b fe=%b d=%h",
                 rdy8, pe8, fe8, dout8, q8[0][9], q8[0][8], q8[0][7:0]);
      end
      void'(q8.pop_front());
      do_pop(1'b0);
    end
    pm8 = 2'b00;
  endtask

  task automatic test_glitch;
    rxd8 = 1'b0;
    wait_cyc(4);
    rxd8 = 1'b1;
    wait_cyc(40);
    n_tests++;
    if ({rdy8, cnt8} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL glitch_start: got rdy=%b cnt=%0d want 0 0", rdy8, cnt8);
    end
    // spikes inside data bits, centred on the sample window
    send_frame(1'b0, 8'h00, 8, 1'b0, 1'b0, 1'b1, 16, 4, 8, -1, -1);
    q8.push_back(exp_entry(8'h00, 8, 2'b00, 1'b0, 1'b1));
    send_frame(1'b0, 8'hFF, 8, 1'b0, 1'b0, 1'b1, 16, 6, 9, -1, -1);
    q8.push_back(exp_entry(8'hFF, 8, 2'b00, 1'b0, 1'b1));
    n_tests++;
    if (cnt8 !== 3'd2) begin
      n_fail++;
      $display("FAIL glitch_cnt: got %0d want 2", cnt8);
    end
    while (q8.size() > 0) begin
      n_tests++;
      if ({rdy8, pe8, fe8, dout8} !== {1'b1, q8[0]}) begin
        n_fail++;
        $display("FAIL glitch_spike: got d=%h fe=%b want d=%h fe=%b", dout8, fe8, q8[0][7:0], q8[0][8]);
      end
      void'(q8.pop_front());
      do_pop(1'b0);
    end
  endtask

  task automatic test_overrun;
    ovr_m = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(1'b0, 8'(k), 8, 1'b0, 1'b0, 1'b1, 16, -1, 0, -1, -1);
      if (q8.size() < 4) q8.push_back(exp_entry(8'(k), 8, 2'b00, 1'b0, 1'b1));
      else ovr_m = 1'b1;
    end
    n_tests++;
    if ({cnt8, ovr8} !== {3'(q8.size()), ovr_m}) begin
      n_fail++;
      $display("FAIL ovr_set: got cnt=%0d ovr=%b want %0d %b", cnt8, ovr8, q8.size(), ovr_m);
    end
    clr8 = 1'b1;
    wait_cyc(1);
    clr8 = 1'b0;
    n_tests++;
    if (ovr8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clr: got ovr=%b want 0", ovr8);
    end
    // done lands on the push cycle: start edge + 2 sync + 1 edge stage,
    // 9 bit periods, then the sample point half+1
    send_frame(1'b0, 8'h06, 8, 1'b0, 1'b0, 1'b1, 16, -1, 0, 3 + 9 * 16 + 8 + 1, -1);
    void'(q8.pop_front());
    q8.push_back(exp_entry(8'h06, 8, 2'b00, 1'b0, 1'b1));
    n_tests++;
    if ({cnt8, ovr8} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL ovr_pushpop: got cnt=%0d ovr=%b want 4 0", cnt8, ovr8);
    end
    while (q8.size() > 0) begin
      n_tests++;
      if ({rdy8, pe8, fe8, dout8} !== {1'b1, q8[0]}) begin
        n_fail++;
        $display("FAIL ovr_entry: got rdy=%b d=%h want d=%h", rdy8, dout8, q8[0][7:0]);
      end
      void'(q8.pop_front());
      do_pop(1'b0);
    end
    do_pop(1'b0);  // pop on empty must be ignored
    n_tests++;
    if ({rdy8, cnt8} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL pop_empty: got rdy=%b cnt=%0d want 0 0", rdy8, cnt8);
    end
  endtask

  task automatic test_break;
    rxd8 = 1'b0;
    wait_cyc(12 * 16);
    n_tests++;
    if ({cnt8, dout8, fe8, pe8} !== {3'd1, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL break_entry: got cnt=%0d d=%h fe=%b pe=%b want 1 00 1 0", cnt8, dout8, fe8, pe8);
    end
    rxd8 = 1'b1;
    wait_cyc(48);
    n_tests++;
    if (cnt8 !== 3'd1) begin
      n_fail++;
      $display("FAIL break_single: got cnt=%0d want 1", cnt8);
    end
    do_pop(1'b0);
    send_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b1, 16, -1, 0, -1, -1);
    n_tests++;
    if ({rdy8, dout8, fe8} !== {1'b1, 8'h3C, 1'b0}) begin
      n_fail++;
      $display("FAIL break_recover: got rdy=%b d=%h fe=%b want 1 3c 0", rdy8, dout8, fe8);
    end
    do_pop(1'b0);
  endtask

  task automatic test_random;
    int         dv;
    int         nfr;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    for (int r = 0; r < 6; r++) begin
      dv   = 16 + int'($urandom_range(0, 8));
      div8 = 16'(dv);
      pm8  = 2'($urandom_range(0, 3));
      nfr  = int'($urandom_range(1, 4));
      for (int f = 0; f < nfr; f++) begin
        d  = 8'($urandom);
        pb = 1'($urandom);
        sb = ($urandom_range(0, 3) != 0);
        send_frame(1'b0, d, 8, par_on(pm8), pb, sb, dv, -1, 0, -1, -1);
        q8.push_back(exp_entry(d, 8, pm8, pb, sb));
        wait_cyc(2 * dv);
      end
      n_tests++;
      if ({cnt8, ovr8} !== {3'(q8.size()), 1'b0}) begin
        n_fail++;
        $display("FAIL rand_cnt r%0d: got cnt=%0d ovr=%b want %0d 0", r, cnt8, ovr8, q8.size());
      end
      while (q8.size() > 0) begin
        n_tests++;
        if ({rdy8, pe8, fe8, dout8} !== {1'b1, q8[0]}) begin
          n_fail++;
          $display("FAIL rand_entry r%0d pm=%0d: got rdy=%b pe=%b fe=%b d=%h want pe=%b fe=%b d=%h",
                   r, pm8, rdy8, pe8, fe8, dout8, q8[0][9], q8[0][8], q8[0][7:0]);
        end
        void'(q8.pop_front());
        do_pop(1'b0);
      end
    end
    div8 = 16'd16;
    pm8  = 2'b00;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++)
      send_frame(1'b1, 8'hFF, 7, 1'b0, 1'b0, 1'b1, 434, -1, 0, -1, -1);
    wait_cyc(10);
    n_tests++;
    if (cnt7 !== 5'd3) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d want 3", cnt7);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({rdy7, dout7, fe7, pe7} !== {1'b1, 8'h7F, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_entry%0d: got rdy=%b d=%h fe=%b pe=%b want 1 7f 0 0", k, rdy7, dout7, fe7, pe7);
      end
      do_pop(1'b1);
    end
    // first frame lands, reset hits during data bit 3 of the second
    send_frame(1'b1, 8'hFF, 7, 1'b0, 1'b0, 1'b1, 434, -1, 0, -1, -1);
    send_frame(1'b1, 8'hFF, 7, 1'b0, 1'b0, 1'b1, 434, -1, 0, -1, 4 * 434 + 200);
    n_tests++;
    if (snap !== 17'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got outputs %h want 0", snap);
    end
    wait_cyc(2 * 434);
    n_tests++;
    if ({rdy7, cnt7} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL rst_after: got rdy=%b cnt=%0d want 0 0", rdy7, cnt7);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_overrun();
    test_break();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
